// File: rtl/uc_pkg.sv
// Shared opcode constants, ALU command encodings, FSM state enum and decode record.
package uc_pkg;

   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_SD  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   localparam logic [2:0] ULA_ADD = 3'b010;
   localparam logic [2:0] ULA_SUB = 3'b110;
   localparam logic [2:0] ULA_AND = 3'b000;
   localparam logic [2:0] ULA_OR  = 3'b001;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_WB,
      ST_HALT
   } state_t;

   typedef struct packed {
      logic       ld;
      logic       sd;
      logic       alu_r;
      logic       alu_i;
      logic       beq;
      logic       illegal;
      logic [2:0] ula_cmd;
   } dec_t;

endpackage

// File: rtl/uc_sequencer_if.sv
// Instruction/status inputs and datapath control outputs of the sequencer.
interface uc_sequencer_if;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic       mem_ready;
   logic       d_mem_we;
   logic       rf_we;
   logic       ula_src;
   logic       pc_src;
   logic       rf_src;
   logic [2:0] ula_cmd;
   logic       pc_we;
   logic       mem_err;
   logic       illegal;

   modport master (
      input  opcode, funct3, funct7b5, zero, mem_ready,
      output d_mem_we, rf_we, ula_src, pc_src, rf_src, ula_cmd, pc_we, mem_err, illegal
   );

   modport slave (
      output opcode, funct3, funct7b5, zero, mem_ready,
      input  d_mem_we, rf_we, ula_src, pc_src, rf_src, ula_cmd, pc_we, mem_err, illegal
   );
endinterface

// File: rtl/uc_decoder.sv
// Purely combinational opcode/funct decode into instruction class and ALU command.
module uc_decoder
   import uc_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   output dec_t       dec
);

   always_comb begin
      dec         = '0;
      dec.ula_cmd = ULA_ADD;
      case (opcode)
         OP_LD:   dec.ld      = 1'b1;
         OP_SD:   dec.sd      = 1'b1;
         OP_R:    dec.alu_r   = 1'b1;
         OP_I:    dec.alu_i   = 1'b1;
         OP_BEQ:  dec.beq     = 1'b1;
         default: dec.illegal = 1'b1;
      endcase

      if (dec.beq) begin
         dec.ula_cmd = ULA_SUB;
      end else if (dec.alu_r || dec.alu_i) begin
         case (funct3)
            3'b111:  dec.ula_cmd = ULA_AND;
            3'b110:  dec.ula_cmd = ULA_OR;
            // funct7b5 only selects SUB for register ops; ADDI has no subtract form
            3'b000:  dec.ula_cmd = (dec.alu_r && funct7b5) ? ULA_SUB : ULA_ADD;
            default: dec.ula_cmd = ULA_ADD;
         endcase
      end
   end

endmodule

// File: rtl/uc_sequencer.sv
// Multi-cycle control FSM: 4 cycles per instruction, LD/SD add MEM cycles until mem_ready or timeout.
// Optional UC_ILLEGAL_TRAP_EN: illegal opcodes halt until reset instead of executing as NOP.
module uc_sequencer
   import uc_pkg::*;
#(
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic           clk,
   input  logic           rst_n,
   uc_sequencer_if.master bus
);

   localparam int CW = $clog2(MEM_WAIT_MAX + 1);

   state_t        state, state_nxt;
   logic [6:0]    op_q;
   logic [2:0]    f3_q;
   logic          f7_q;
   logic          zero_q;
   logic          tmo_q;
   logic          mem_err_q;
   logic          illegal_q;
   logic [CW-1:0] wait_cnt;
   logic          timeout;

   logic [6:0]    dec_op;
   logic [2:0]    dec_f3;
   logic          dec_f7;
   dec_t          dec;

   // Live bits only matter in DECODE (illegal detection); every output-driving state uses the latched copy.
   assign dec_op = (state == ST_DECODE) ? bus.opcode   : op_q;
   assign dec_f3 = (state == ST_DECODE) ? bus.funct3   : f3_q;
   assign dec_f7 = (state == ST_DECODE) ? bus.funct7b5 : f7_q;

   uc_decoder u_dec (
      .opcode   (dec_op),
      .funct3   (dec_f3),
      .funct7b5 (dec_f7),
      .dec      (dec)
   );

   assign timeout = (state == ST_MEM) && !bus.mem_ready
                    && (wait_cnt == CW'(MEM_WAIT_MAX - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_FETCH;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q      <= '0;
         f3_q      <= '0;
         f7_q      <= 1'b0;
         zero_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         if (state == ST_DECODE) begin
            op_q <= bus.opcode;
            f3_q <= bus.funct3;
            f7_q <= bus.funct7b5;
            if (dec.illegal) begin
               illegal_q <= 1'b1;
            end
         end
         if (state == ST_EXEC) begin
            zero_q <= bus.zero;
         end
      end
   end

   // tmo_q marks only the current instruction; mem_err_q is the sticky report.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt  <= '0;
         tmo_q     <= 1'b0;
         mem_err_q <= 1'b0;
      end else begin
         if (state == ST_MEM) begin
            wait_cnt <= wait_cnt + 1'b1;
         end else begin
            wait_cnt <= '0;
         end
         if (state == ST_FETCH) begin
            tmo_q <= 1'b0;
         end
         if (timeout) begin
            tmo_q     <= 1'b1;
            mem_err_q <= 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      bus.d_mem_we = 1'b0;
      bus.rf_we    = 1'b0;
      bus.ula_src  = 1'b0;
      bus.pc_src   = 1'b0;
      bus.rf_src   = 1'b0;
      bus.pc_we    = 1'b0;
      bus.ula_cmd  = ULA_ADD;

      case (state)
         ST_FETCH: state_nxt = ST_DECODE;
         ST_DECODE: begin
`ifdef UC_ILLEGAL_TRAP_EN
            state_nxt = dec.illegal ? ST_HALT : ST_EXEC;
`else
            state_nxt = ST_EXEC;
`endif
         end
         ST_EXEC:  state_nxt = (dec.ld || dec.sd) ? ST_MEM : ST_WB;
         ST_MEM: begin
            if (bus.mem_ready || timeout) begin
               state_nxt = ST_WB;
            end
         end
         ST_WB:    state_nxt = ST_FETCH;
         ST_HALT:  state_nxt = ST_HALT;
         default:  state_nxt = ST_FETCH;
      endcase

      if (state inside {ST_EXEC, ST_MEM, ST_WB}) begin
         bus.ula_cmd = dec.ula_cmd;
         bus.ula_src = dec.ld || dec.sd || dec.alu_i;
      end
      if (state == ST_MEM) begin
         bus.d_mem_we = dec.sd;
         bus.rf_src   = dec.ld;
      end
      if (state == ST_WB) begin
         bus.rf_we  = (dec.ld || dec.alu_r || dec.alu_i) && !tmo_q;
         bus.rf_src = dec.ld;
         bus.pc_we  = 1'b1;
         bus.pc_src = dec.beq && zero_q;
      end
   end

   assign bus.mem_err = mem_err_q;
   assign bus.illegal = illegal_q;

endmodule
